if_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core, directly upstream of the decode logic that feeds `controller` and `datapath`. It holds the fetch program counter (PCF) and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register. It applies stall, flush and branch/jump redirects from the execute stage and hazard unit. Decode consumes `instrD`, `PCD` and `PCPlus4D` one cycle after fetch.

---
 rtl/if_stage.sv | 75 +++++++
 tb/tb_if_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC register, next-PC mux and IF/ID pipeline register.
// Optional IF_PERF_CNT_EN adds fetch_cnt / flush_cnt performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] PCNextF;
  logic        load_pc;
  logic        load_id;

  assign PCPlus4F  = PCF + 32'd4;
  assign PCNextF   = PCSrcE ? {PCTargetE[31:2], 2'b00} : PCPlus4F;
  assign imem_addr = PCF;

  // A redirect overrides stallF so a resolved branch is never dropped.
  assign load_pc = PCSrcE || !stallF;
  assign load_id = !flushD && !stallD;

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (load_pc) begin
      PCF <= PCNextF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (load_id) begin
      instrD   <= imem_rdata;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      validD   <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_id) fetch_cnt <= fetch_cnt + 32'd1;
      if (flushD)  flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios followed by randomized stall/flush/redirect traffic.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] imem_addr, imem_rdata, instrD, PCD, PCPlus4D;
  logic        validD;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .validD(validD)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Instruction memory contents: a few fixed program words, a scrambled pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      default:       return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [31:0] addr, instr, pcd, pc4;
    logic        valid;
    logic [31:0] fc, flc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc = RST_PC, m_instr = NOP, m_pcd = '0, m_pc4 = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fc = '0, m_flc = '0;

  task automatic step(input logic r, input logic sf, input logic sd,
                      input logic fd, input logic ps, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    rst = r; stallF = sf; stallD = sd; flushD = fd; PCSrcE = ps; PCTargetE = tgt;
    if (r) begin
      m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      m_fc = 0; m_flc = 0;
    end else begin
      if (fd) begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        m_flc = m_flc + 1;
      end else if (!sd) begin
        m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
        m_fc = m_fc + 1;
      end
      if (ps)       m_pc = tgt & 32'hFFFF_FFFC;
      else if (!sf) m_pc = m_pc + 4;
    end
    e.addr = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4;
    e.valid = m_valid; e.fc = m_fc; e.flc = m_flc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every edge, compare DUT state against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("instrD", instrD, e.instr);
        chk("PCD", PCD, e.pcd);
        chk("PCPlus4D", PCPlus4D, e.pc4);
        chk("validD", {31'b0, validD}, {31'b0, e.valid});
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, e.fc);
        chk("flush_cnt", flush_cnt, e.flc);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout pending=%0d required=0", exp_q.size());
    $fatal(1);
  end

  initial begin
    logic r, sf, sd, fd, ps;
    int unsigned p;
    // Reset held two cycles, then first fetch from RESET_PC
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Redirect to 0, then sequential program fetch
    step(0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Redirect+flush with misaligned target while PCF=8
    step(0, 0, 0, 1, 1, 32'h0000_0043);
    step(0, 0, 0, 0, 0, 0);
    // Load-use stall at PCF=0x10
    step(0, 0, 0, 1, 1, 32'h0000_0010);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Priorities: redirect over stallF, flush over stallD
    step(0, 1, 0, 0, 1, 32'h0000_0200);
    step(0, 0, 1, 1, 0, 0);
    // PC wrap at the top of the address space
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Counter scenario: 5 fetches, 1 flush, then reset mid-run
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Randomized traffic
    repeat (400) begin
      p  = $urandom_range(0, 99);
      r  = (p < 2);
      sf = 0; sd = 0; fd = 0; ps = 0;
      if (p >= 2 && p < 20) begin
        sf = 1; sd = 1;
      end else if (p >= 20 && p < 35) begin
        ps = 1; fd = 1;
      end else if (p >= 35 && p < 50) begin
        {sf, sd, fd, ps} = 4'($urandom_range(0, 15));
      end
      step(r, sf, sd, fd, ps, $urandom);
    end
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
